// File: rtl/if_pkg.sv
// Shared fetch-stage types: XLEN, reset vector default, FSM states and the buffered {pc, instr} entry.
package if_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction buffer; head visible the cycle after push, no bypass.
// Push while full is accepted only together with a pop; flush empties it in one cycle.
module fetch_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output fetch_entry_t                 head
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

   // Storage carries no reset; validity is tracked solely by count.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: issues one read per cycle while buffer space (count+inflight) allows; issue-to-Instr_Valid is 2 cycles.
// Decode backpressure (Instr_Ready=0) stalls issue and holds PC; redirect flushes and outranks pop/push/issue.
module if_stage
   import if_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter int              DEPTH        = 2
)(
   input  logic              CLK,
   input  logic              rst,
   input  logic [XLEN-1:0]   PC,
   output logic [XLEN-1:0]   PC_Next,
   input  logic              Redirect_Valid,
   input  logic [XLEN-1:0]   Redirect_Target,
   output logic              IMem_Req,
   output logic [XLEN-1:0]   IMem_Addr,
   input  logic              IMem_RValid,
   input  logic [XLEN-1:0]   IMem_RData,
   output logic              Instr_Valid,
   input  logic              Instr_Ready,
   output logic [XLEN-1:0]   Instr,
   output logic [XLEN-1:0]   Instr_PC
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_t    state_q;
   fetch_state_t    fsm;
   logic            inflight;
   logic [XLEN-1:0] inflight_addr;
   logic            discard;

   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   fetch_entry_t    head;
   fetch_entry_t    push_data;

   logic            accept;
   logic            pop;
   logic            push;
   logic            issue;
   logic            flush;
   logic [CW:0]     occ;
   logic [CW:0]     limit;

   // S_RESET is what the stage is in while rst is held; the register restarts in
   // S_START so the first cycle after release never issues or accepts data.
   assign fsm = rst ? S_RESET : state_q;

   assign flush       = Redirect_Valid && !rst;
   assign Instr_Valid = (fsm != S_RESET) && !fifo_empty;
   assign accept      = Instr_Valid && Instr_Ready;
   assign pop         = accept && !Redirect_Valid;

   assign occ   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
   assign limit = (CW+1)'(DEPTH) + {{CW{1'b0}}, accept};
   assign issue = (fsm == S_RUN) && !Redirect_Valid && (occ < limit);

   assign push = (fsm == S_RUN) && !Redirect_Valid && IMem_RValid && !discard
                 && (!fifo_full || pop);
   assign push_data = '{pc: inflight_addr, instr: IMem_RData};

   assign IMem_Req  = issue;
   assign IMem_Addr = issue ? PC : '0;
   assign Instr     = Instr_Valid ? head.instr : '0;
   assign Instr_PC  = Instr_Valid ? head.pc : '0;

   always_comb begin
      PC_Next = PC;
      if (rst)
         PC_Next = RESET_VECTOR;
      else if (Redirect_Valid)
         PC_Next = align_pc(Redirect_Target);
      else if (issue)
         PC_Next = PC + XLEN'(4);
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q       <= S_START;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         discard       <= 1'b0;
      end else begin
         unique case (state_q)
            S_RESET: state_q <= S_START;
            S_START: state_q <= S_RUN;
            default: state_q <= S_RUN;
         endcase
         inflight <= issue;
         if (issue)
            inflight_addr <= PC;
         discard <= Redirect_Valid && inflight;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (head)
   );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: per-cycle vector table plus a reset-mid-flight sequence; a scoreboard
// queue holds every issued fetch and is matched against each instruction decode accepts.
module tb_if_stage;
   import if_pkg::*;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        CLK;
   logic        rst;
   logic [31:0] PC;
   logic [31:0] PC_Next;
   logic        Redirect_Valid;
   logic [31:0] Redirect_Target;
   logic        IMem_Req;
   logic [31:0] IMem_Addr;
   logic        IMem_RValid;
   logic [31:0] IMem_RData;
   logic        Instr_Valid;
   logic        Instr_Ready;
   logic [31:0] Instr;
   logic [31:0] Instr_PC;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [31:0] last_nxt;
   fetch_entry_t sb[$];

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] tgt;
      logic        inj;
      logic        e_req;
      logic        e_vld;
      logic [31:0] e_ipc;
      logic        cn;
      logic [31:0] e_nxt;
   } vec_t;

   vec_t tv [31];

   if_stage #(
      .RESET_VECTOR (RV),
      .DEPTH        (2)
   ) dut (
      .CLK             (CLK),
      .rst             (rst),
      .PC              (PC),
      .PC_Next         (PC_Next),
      .Redirect_Valid  (Redirect_Valid),
      .Redirect_Target (Redirect_Target),
      .IMem_Req        (IMem_Req),
      .IMem_Addr       (IMem_Addr),
      .IMem_RValid     (IMem_RValid),
      .IMem_RData      (IMem_RData),
      .Instr_Valid     (Instr_Valid),
      .Instr_Ready     (Instr_Ready),
      .Instr           (Instr),
      .Instr_PC        (Instr_PC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h0000_0013;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock: sample at negedge, score, then after posedge load PC and return memory data.
   task automatic tick(input logic chk, input logic e_req, input logic e_vld, input logic [31:0] e_ipc);
      logic        req_s;
      logic [31:0] addr_s;
      logic [31:0] nxt_s;
      logic [31:0] exp_nxt;
      fetch_entry_t e;
      @(negedge CLK);
      req_s  = IMem_Req;
      addr_s = IMem_Addr;
      nxt_s  = PC_Next;
      last_nxt = nxt_s;
      if (rst) begin
         check("rst_pc_next", nxt_s, RV);
         check("rst_req", 32'(req_s), 32'd0);
         check("rst_valid", 32'(Instr_Valid), 32'd0);
         check("rst_addr", addr_s, 32'd0);
         check("rst_instr", Instr, 32'd0);
         check("rst_instr_pc", Instr_PC, 32'd0);
         sb.delete();
      end else begin
         if (Redirect_Valid)
            exp_nxt = Redirect_Target & 32'hFFFF_FFFC;
         else if (req_s)
            exp_nxt = PC + 32'd4;
         else
            exp_nxt = PC;
         check("pc_next", nxt_s, exp_nxt);
         if (req_s) check("imem_addr", addr_s, PC);
         if (chk) begin
            check("req", 32'(req_s), 32'(e_req));
            check("instr_valid", 32'(Instr_Valid), 32'(e_vld));
            if (e_vld) begin
               check("instr_pc", Instr_PC, e_ipc);
               check("instr", Instr, mem_word(e_ipc));
            end
         end
         if (Instr_Valid && Instr_Ready && !Redirect_Valid) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_unexpected cycle %0d: got pc %h expected no instruction", cyc, Instr_PC);
            end else begin
               e = sb.pop_front();
               check("sb_pc", Instr_PC, e.pc);
               check("sb_instr", Instr, e.instr);
            end
         end
         if (Redirect_Valid) sb.delete();
         if (req_s && !Redirect_Valid) sb.push_back('{pc: addr_s, instr: mem_word(addr_s)});
      end
      @(posedge CLK);
      #1;
      cyc++;
      PC          = nxt_s;
      IMem_RValid = req_s;
      IMem_RData  = req_s ? mem_word(addr_s) : 32'h0;
   endtask

   initial begin
      //          rdy  rv   tgt           inj  req  vld  ipc           cn   nxt
      tv[0]  = '{1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0};
      tv[1]  = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b1,32'h4};
      tv[2]  = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0};
      tv[3]  = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h0,        1'b0,32'h0};
      tv[4]  = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h4,        1'b0,32'h0};
      tv[5]  = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h8,        1'b0,32'h0};
      tv[6]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'hC,        1'b0,32'h0};
      tv[7]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'hC,        1'b1,32'h14};
      tv[8]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'hC,        1'b0,32'h0};
      tv[9]  = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'hC,        1'b0,32'h0};
      tv[10] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'hC,        1'b0,32'h0};
      tv[11] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'hC,        1'b0,32'h0};
      tv[12] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h10,       1'b0,32'h0};
      tv[13] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h14,       1'b0,32'h0};
      tv[14] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h18,       1'b0,32'h0};
      tv[15] = '{1'b1,1'b1,32'h103,      1'b0,1'b0,1'b1,32'h1C,       1'b1,32'h100};
      tv[16] = '{1'b1,1'b0,32'h0,        1'b1,1'b1,1'b0,32'h0,        1'b1,32'h104};
      tv[17] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0};
      tv[18] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h100,      1'b0,32'h0};
      tv[19] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h104,      1'b0,32'h0};
      tv[20] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h108,      1'b0,32'h0};
      tv[21] = '{1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,32'h108,      1'b0,32'h0};
      tv[22] = '{1'b1,1'b1,32'h40,       1'b0,1'b0,1'b1,32'h108,      1'b1,32'h40};
      tv[23] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0};
      tv[24] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0};
      tv[25] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h40,       1'b0,32'h0};
      tv[26] = '{1'b1,1'b1,32'hFFFFFFFF, 1'b0,1'b0,1'b1,32'h44,       1'b1,32'hFFFFFFFC};
      tv[27] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0};
      tv[28] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0};
      tv[29] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'hFFFFFFFC, 1'b0,32'h0};
      tv[30] = '{1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h0,        1'b0,32'h0};

      rst             = 1'b1;
      PC              = 32'h0000_1230;
      Redirect_Valid  = 1'b0;
      Redirect_Target = 32'h0;
      IMem_RValid     = 1'b0;
      IMem_RData      = 32'h0;
      Instr_Ready     = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 31; i++) begin
         Instr_Ready     = tv[i].rdy;
         Redirect_Valid  = tv[i].rv;
         Redirect_Target = tv[i].tgt;
         if (tv[i].inj) begin
            IMem_RValid = 1'b1;
            IMem_RData  = 32'hDEAD_BEEF;
         end
         tick(1'b1, tv[i].e_req, tv[i].e_vld, tv[i].e_ipc);
         if (tv[i].cn) check("vec_pc_next", last_nxt, tv[i].e_nxt);
      end
      Redirect_Valid  = 1'b0;
      Redirect_Target = 32'h0;

      // Reset while an entry is buffered and a read is in flight; a stray
      // response in the first cycle after release must not reach decode.
      Instr_Ready = 1'b1;
      rst = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      IMem_RValid = 1'b1;
      IMem_RData  = 32'hDEAD_BEEF;
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      check("post_rst_pc", PC, RV);
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b1, 1'b1, 32'h0);
      tick(1'b1, 1'b1, 1'b1, 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning PC_Next value driven during reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning instruction buffer entries (power of two, 2..4).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port PC  input  32  current PC from the program counter register.
REQ-006 SHALL have port PC_Next  output  32  next PC to the program counter register.
REQ-007 SHALL have port Redirect_Valid  input  1  branch/jump redirect from execute.
REQ-008 SHALL have port Redirect_Target  input  32  redirect destination address.
REQ-009 SHALL have port IMem_Req  output  1  instruction memory read request.
REQ-010 SHALL have port IMem_Addr  output  32  read address; equals PC when IMem_Req=1.
REQ-011 SHALL have port IMem_RValid  input  1  read data valid, exactly one cycle after IMem_Req.
REQ-012 SHALL have port IMem_RData  input  32  instruction word.
REQ-013 SHALL have port Instr_Valid  output  1  buffer head valid toward decode.
REQ-014 SHALL have port Instr_Ready  input  1  decode accepts head.
REQ-015 SHALL have port Instr  output  32  head instruction word.
REQ-016 SHALL have port Instr_PC  output  32  PC of head instruction.

Function
REQ-017 SHALL keep a DEPTH-entry FIFO of {pc, instr}; pop when Instr_Valid && Instr_Ready.
REQ-018 SHALL keep an inflight bit (request issued last cycle) and its address register.
REQ-019 SHALL issue (IMem_Req=1) in RUN when count + inflight - pop < DEPTH and Redirect_Valid=0.
REQ-020 SHALL drive PC_Next = PC+4 on issue, PC_Next = PC (hold) otherwise, wrapping modulo 2^32.
REQ-021 SHALL push {inflight address, IMem_RData} when IMem_RValid=1 and discard flag clear.
REQ-022 SHALL, on Redirect_Valid=1, drive PC_Next = {Redirect_Target[31:2],2'b00}, flush FIFO, set discard if inflight, and issue no request that cycle.
REQ-023 SHALL drop the response arriving the cycle after a redirect and then clear discard.
REQ-024 SHALL give Redirect_Valid priority over pop, push and issue in the same cycle; Instr_Valid=0 the cycle after redirect.
REQ-025 SHALL allow simultaneous push and pop when full (count unchanged, no overflow); never push when count=DEPTH.
REQ-026 SHALL use FSM: S_RESET (during rst) -> S_START (one cycle, no request) -> S_RUN; redirect stays in S_RUN.
REQ-027 SHALL deliver first instruction with latency 2 cycles from issue to Instr_Valid (issue, response/push, visible).
REQ-028 SHALL sustain one instruction per cycle when Instr_Ready is held high.
REQ-029 SHALL keep Instr and Instr_PC stable while Instr_Valid=1 and Instr_Ready=0.

Reset
REQ-030 SHALL, while rst=1, drive PC_Next=RESET_VECTOR, IMem_Req=0, Instr_Valid=0, IMem_Addr=0, Instr=0, Instr_PC=0.
REQ-031 SHALL clear count, pointers, inflight and discard on rst; rst mid-operation drops all buffered and inflight data.
REQ-032 SHALL ignore IMem_RValid in the cycle after rst deasserts.

Structure
REQ-033 SHALL place XLEN=32, RESET_VECTOR default, FSM enum and fetch entry struct in shared package if_pkg.
REQ-034 SHALL implement the buffer as sub-module fetch_fifo (push, pop, flush, full, empty, count).

Verification
REQ-035 Reset release, PC=0, Instr_Ready=1, memory returns 0x00000013 -> Instr_Valid at cycle 3 with Instr_PC=0, then 4, 8 back-to-back.
REQ-036 Instr_Ready=0 for 5 cycles -> two entries buffered, IMem_Req=0, PC_Next=PC; outputs stable; resume yields no lost or duplicated PCs.
REQ-037 Redirect_Valid with target 0x00000103 while inflight -> PC_Next=0x00000100, stale response dropped, next Instr_PC=0x00000100.
REQ-038 Redirect and pop in same cycle with FIFO full -> FIFO empty next cycle, no pop side effects.
REQ-039 PC=0xFFFFFFFC issue -> PC_Next=0x00000000.
REQ-040 rst asserted with FIFO full and inflight -> next cycle Instr_Valid=0, PC_Next=RESET_VECTOR, late IMem_RValid ignored.
